// File: rtl/toe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : toe_pkg
// Purpose : Shared types and constants for the TCP connection-table engine:
//           request codes, reply status codes, entry word offsets, FSM states
//           and the read-tag record that follows a RAM read down its latency.
// Revision: 1.0 - initial release
// ============================================================================
package toe_pkg;

    localparam int SLOT_W = 6;

    typedef enum logic [1:0] {
        REQ_NONE   = 2'b00,
        REQ_OPEN   = 2'b01,
        REQ_CLOSE  = 2'b10,
        REQ_LOOKUP = 2'b11
    } req_code_e;

    localparam logic [1:0] ST_OK  = 2'b01;
    localparam logic [1:0] ST_NF  = 2'b10;
    localparam logic [1:0] ST_DUP = 2'b11;

    // Word offsets inside one 8-word entry
    localparam logic [2:0] W_HDR   = 3'd0;
    localparam logic [2:0] W_IPS   = 3'd1;
    localparam logic [2:0] W_IPD   = 3'd2;
    localparam logic [2:0] W_MACS  = 3'd3;
    localparam logic [2:0] W_MIX   = 3'd4;
    localparam logic [2:0] W_MACD  = 3'd5;
    localparam logic [2:0] W_PORTS = 3'd6;
    localparam logic [2:0] W_RSVD  = 3'd7;

    typedef enum logic [2:0] {
        CLEAR     = 3'd0,
        WAIT_RQ   = 3'd1,
        SEARCH    = 3'd2,
        WRITE     = 3'd3,
        CLOSE_CHK = 3'd4,
        RETURN    = 3'd5
    } state_e;

    // Travels alongside an outstanding read so the returning q word can be
    // attributed to its slot and word offset.
    typedef struct packed {
        logic              vld;
        logic [2:0]        word;
        logic [SLOT_W-1:0] slot;
    } rd_tag_t;

    // The four words a search needs, in issue order.
    function automatic logic [2:0] search_word(input logic [1:0] idx);
        case (idx)
            2'd0:    return W_HDR;
            2'd1:    return W_IPS;
            2'd2:    return W_IPD;
            default: return W_PORTS;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/toe_entry_cmp.sv
`default_nettype none
// ============================================================================
// Module  : toe_entry_cmp
// Purpose : Registered per-slot 4-tuple comparator. Consumes the words of one
//           entry as they return from RAM (header first) and accumulates a
//           match flag; results are valid the cycle after the ports word.
// Ports   : clk, rst        - clock, async active-high reset
//           en_i, word_i    - q_i carries entry word word_i this cycle
//           q_i             - RAM read data
//           ip_src_i, ip_dst_i, ports_i - key being searched
//           match_o, free_o - slot valid and equal / slot invalid
// Revision: 1.0 - initial release
// ============================================================================
module toe_entry_cmp
    import toe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic [2:0]  word_i,
    input  logic [31:0] q_i,
    input  logic [31:0] ip_src_i,
    input  logic [31:0] ip_dst_i,
    input  logic [31:0] ports_i,
    output logic        match_o,
    output logic        free_o
);

    logic        valid_q;
    logic        eq_q;
    logic [31:0] exp_word;

    always_comb begin
        exp_word = 32'd0;
        case (word_i)
            W_IPS:   exp_word = ip_src_i;
            W_IPD:   exp_word = ip_dst_i;
            W_PORTS: exp_word = ports_i;
            default: exp_word = 32'd0;
        endcase
    end

    // Header word restarts the accumulation for a new slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            eq_q    <= 1'b0;
        end else if (en_i) begin
            if (word_i == W_HDR) begin
                valid_q <= q_i[31];
                eq_q    <= 1'b1;
            end else begin
                eq_q    <= eq_q & (q_i == exp_word);
            end
        end
    end

    assign match_o = valid_q & eq_q;
    assign free_o  = ~valid_q;

endmodule
`default_nettype wire

// File: rtl/toe_conn_table.sv
`default_nettype none
// ============================================================================
// Module  : toe_conn_table
// Purpose : TCP connection-table engine. Keeps NUM_ENTRIES 8-word socket
//           entries in an external single-port RAM and serves OPEN / CLOSE /
//           LOOKUP with a level-held request/reply handshake.
// Ports   : clk, rst          - clock, async active-high reset
//           req_code, id_in   - request code and CLOSE slot index
//           ip_*, mac_*, port_* - connection operands
//           reply             - {status, slot}, 0 when idle
//           addr, data, wren, q - RAM port (q one cycle after addr)
//           busy, count       - engine busy, number of valid slots
// Revision: 1.0 - initial release
// ============================================================================
module toe_conn_table
    import toe_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    parameter int ADDR_W      = 8,
    parameter int BASE_ADDR   = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [1:0]                         req_code,
    input  logic [7:0]                         id_in,
    input  logic [31:0]                        ip_src,
    input  logic [31:0]                        ip_dst,
    input  logic [47:0]                        mac_src,
    input  logic [47:0]                        mac_dst,
    input  logic [15:0]                        port_src,
    input  logic [15:0]                        port_dst,
    output logic [7:0]                         reply,
    output logic [ADDR_W-1:0]                  addr,
    output logic [31:0]                        data,
    output logic                               wren,
    input  logic [31:0]                        q,
    output logic                               busy,
    output logic [$clog2(NUM_ENTRIES+1)-1:0]   count
);

    localparam int                CNT_W     = $clog2(NUM_ENTRIES + 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_ENTRIES - 1);

    if (NUM_ENTRIES < 1 || NUM_ENTRIES > 64 ||
        (64'(BASE_ADDR) + 64'(8 * NUM_ENTRIES)) > (64'd1 << ADDR_W)) begin : g_param_check
        $error("toe_conn_table: table does not fit the RAM address space");
    end

    state_e             state_q, state_d;
    req_code_e          op_q, op_d;
    logic [SLOT_W-1:0]  id_q, id_d;
    logic [31:0]        ips_q, ips_d, ipd_q, ipd_d, ports_q, ports_d;
    logic [47:0]        macs_q, macs_d, macd_q, macd_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [2:0]         widx_q, widx_d;
    logic               iss_done_q, iss_done_d;
    logic               free_found_q, free_found_d;
    logic [SLOT_W-1:0]  free_slot_q, free_slot_d;
    rd_tag_t            tag1_q, tag1_d, tag2_q, tag3_q;
    logic [7:0]         reply_q, reply_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        data_q, data_d;
    logic               wren_q, wren_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               cmp_match, cmp_free;
    logic [2:0]         wr_word;
    logic [31:0]        wr_data;
    logic               unused_id_bits;

    assign unused_id_bits = ^id_in[7:6];

    function automatic logic [ADDR_W-1:0] word_addr(input logic [SLOT_W-1:0] s,
                                                    input logic [2:0] w);
        return ADDR_W'(BASE_ADDR + 8 * int'(s) + int'(w));
    endfunction

    toe_entry_cmp u_cmp (
        .clk      (clk),
        .rst      (rst),
        .en_i     (tag2_q.vld),
        .word_i   (tag2_q.word),
        .q_i      (q),
        .ip_src_i (ips_q),
        .ip_dst_i (ipd_q),
        .ports_i  (ports_q),
        .match_o  (cmp_match),
        .free_o   (cmp_free)
    );

    // Header goes last so a half-written entry is never seen as valid.
    assign wr_word = (widx_q == 3'd7) ? W_HDR : widx_q + 3'd1;

    always_comb begin
        wr_data = 32'd0;
        case (wr_word)
            W_HDR:   wr_data = 32'h8000_0000;
            W_IPS:   wr_data = ips_q;
            W_IPD:   wr_data = ipd_q;
            W_MACS:  wr_data = macs_q[47:16];
            W_MIX:   wr_data = {macs_q[15:0], macd_q[47:32]};
            W_MACD:  wr_data = macd_q[31:0];
            W_PORTS: wr_data = ports_q;
            W_RSVD:  wr_data = 32'd0;
            default: wr_data = 32'd0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        id_d         = id_q;
        ips_d        = ips_q;
        ipd_d        = ipd_q;
        ports_d      = ports_q;
        macs_d       = macs_q;
        macd_d       = macd_q;
        slot_d       = slot_q;
        widx_d       = widx_q;
        iss_done_d   = iss_done_q;
        free_found_d = free_found_q;
        free_slot_d  = free_slot_q;
        tag1_d       = '0;
        reply_d      = reply_q;
        addr_d       = addr_q;
        data_d       = data_q;
        wren_d       = 1'b0;
        count_d      = count_q;

        case (state_q)
            CLEAR: begin
                wren_d = 1'b1;
                addr_d = word_addr(slot_q, W_HDR);
                data_d = 32'd0;
                slot_d = slot_q + 6'd1;
                if (slot_q == LAST_SLOT) begin
                    slot_d  = '0;
                    state_d = WAIT_RQ;
                end
            end

            WAIT_RQ: begin
                if (req_code_e'(req_code) != REQ_NONE) begin
                    op_d         = req_code_e'(req_code);
                    id_d         = id_in[5:0];
                    ips_d        = ip_src;
                    ipd_d        = ip_dst;
                    ports_d      = {port_src, port_dst};
                    macs_d       = mac_src;
                    macd_d       = mac_dst;
                    slot_d       = '0;
                    widx_d       = 3'd0;
                    iss_done_d   = 1'b0;
                    free_found_d = 1'b0;
                    free_slot_d  = '0;
                    state_d      = (req_code_e'(req_code) == REQ_CLOSE) ? CLOSE_CHK : SEARCH;
                end
            end

            SEARCH: begin
                // Issue side: one read per cycle, four words per slot.
                if (!iss_done_q) begin
                    addr_d = word_addr(slot_q, search_word(widx_q[1:0]));
                    tag1_d = '{vld: 1'b1, word: search_word(widx_q[1:0]), slot: slot_q};
                    if (widx_q[1:0] == 2'd3) begin
                        widx_d = 3'd0;
                        if (slot_q == LAST_SLOT) iss_done_d = 1'b1;
                        else                     slot_d     = slot_q + 6'd1;
                    end else begin
                        widx_d = widx_q + 3'd1;
                    end
                end
                // Result side: comparator holds a full slot verdict here.
                if (tag3_q.vld && tag3_q.word == W_PORTS) begin
                    if (cmp_match) begin
                        reply_d = {(op_q == REQ_OPEN) ? ST_DUP : ST_OK, tag3_q.slot};
                        state_d = RETURN;
                    end else begin
                        if (cmp_free && !free_found_q) begin
                            free_found_d = 1'b1;
                            free_slot_d  = tag3_q.slot;
                        end
                        if (tag3_q.slot == LAST_SLOT) begin
                            if (op_q == REQ_LOOKUP || !(free_found_q || cmp_free)) begin
                                reply_d = {ST_NF, 6'd0};
                                state_d = RETURN;
                            end else begin
                                widx_d  = 3'd0;
                                state_d = WRITE;
                            end
                        end
                    end
                end
            end

            WRITE: begin
                wren_d = 1'b1;
                addr_d = word_addr(free_slot_q, wr_word);
                data_d = wr_data;
                widx_d = widx_q + 3'd1;
                if (widx_q == 3'd7) begin
                    count_d = count_q + CNT_W'(1);
                    reply_d = {ST_OK, free_slot_q};
                    state_d = RETURN;
                end
            end

            CLOSE_CHK: begin
                if (int'(id_q) >= NUM_ENTRIES) begin
                    reply_d = {ST_NF, id_q};
                    state_d = RETURN;
                end else if (!iss_done_q) begin
                    addr_d     = word_addr(id_q, W_HDR);
                    tag1_d     = '{vld: 1'b1, word: W_HDR, slot: id_q};
                    iss_done_d = 1'b1;
                end else if (tag2_q.vld) begin
                    if (q[31] && count_q != '0) begin
                        wren_d  = 1'b1;
                        addr_d  = word_addr(id_q, W_HDR);
                        data_d  = 32'd0;
                        count_d = count_q - CNT_W'(1);
                        reply_d = {ST_OK, id_q};
                    end else begin
                        reply_d = {ST_NF, id_q};
                    end
                    state_d = RETURN;
                end
            end

            RETURN: begin
                if (req_code_e'(req_code) == REQ_NONE) begin
                    reply_d = 8'd0;
                    state_d = WAIT_RQ;
                end
            end

            default: state_d = CLEAR;
        endcase

        busy_d = (state_d != WAIT_RQ);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= CLEAR;
            op_q         <= REQ_NONE;
            id_q         <= '0;
            ips_q        <= '0;
            ipd_q        <= '0;
            ports_q      <= '0;
            macs_q       <= '0;
            macd_q       <= '0;
            slot_q       <= '0;
            widx_q       <= '0;
            iss_done_q   <= 1'b0;
            free_found_q <= 1'b0;
            free_slot_q  <= '0;
            tag1_q       <= '0;
            tag2_q       <= '0;
            tag3_q       <= '0;
            reply_q      <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            wren_q       <= 1'b0;
            busy_q       <= 1'b1;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            id_q         <= id_d;
            ips_q        <= ips_d;
            ipd_q        <= ipd_d;
            ports_q      <= ports_d;
            macs_q       <= macs_d;
            macd_q       <= macd_d;
            slot_q       <= slot_d;
            widx_q       <= widx_d;
            iss_done_q   <= iss_done_d;
            free_found_q <= free_found_d;
            free_slot_q  <= free_slot_d;
            tag1_q       <= tag1_d;
            // Drain reads left over from an early-terminated search so they
            // cannot be mistaken for results of the next request.
            tag2_q       <= (state_q == WAIT_RQ) ? '0 : tag1_q;
            tag3_q       <= (state_q == WAIT_RQ) ? '0 : tag2_q;
            reply_q      <= reply_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            wren_q       <= wren_d;
            busy_q       <= busy_d;
            count_q      <= count_d;
        end
    end

    assign reply = reply_q;
    assign addr  = addr_q;
    assign data  = data_q;
    assign wren  = wren_q;
    assign busy  = busy_q;
    assign count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_toe_conn_table.sv
`default_nettype none
// ============================================================================
// Module  : tb_toe_conn_table
// Purpose : Self-checking bench for toe_conn_table: reset/clear behaviour,
//           a directed vector table, randomized requests against a slot-array
//           reference model, and reset in the middle of an entry write.
// Revision: 1.0 - initial release
// ============================================================================
module tb_toe_conn_table;

    localparam int N = 16;

    typedef struct packed {
        logic [31:0] ips;
        logic [31:0] ipd;
        logic [15:0] ps;
        logic [15:0] pd;
        logic [47:0] macs;
        logic [47:0] macd;
    } tuple_t;

    typedef struct {
        logic [1:0] code;
        logic [7:0] id;
        tuple_t     t;
        logic [7:0] exp_reply;
        int         exp_count;
        int         exp_wr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_code;
    logic [7:0]  id_in;
    logic [31:0] ip_src, ip_dst;
    logic [47:0] mac_src, mac_dst;
    logic [15:0] port_src, port_dst;
    logic [7:0]  reply;
    logic [7:0]  addr;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q;
    logic        busy;
    logic [4:0]  count;

    int checks = 0;
    int errors = 0;

    toe_conn_table #(.NUM_ENTRIES(N), .ADDR_W(8), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .req_code(req_code), .id_in(id_in),
        .ip_src(ip_src), .ip_dst(ip_dst), .mac_src(mac_src), .mac_dst(mac_dst),
        .port_src(port_src), .port_dst(port_dst), .reply(reply), .addr(addr),
        .data(data), .wren(wren), .q(q), .busy(busy), .count(count)
    );

    always #5 clk = ~clk;

    // RAM model: unwritten words read back as garbage with bit 31 set.
    logic [31:0]  mem [0:255];
    logic [255:0] wr_seen = '0;

    function automatic logic [31:0] ram_rd(input logic [7:0] a);
        return wr_seen[a] ? mem[a] : {1'b1, 23'd0, a};
    endfunction

    always @(posedge clk) begin
        q <= ram_rd(addr);
        if (wren) begin
            mem[addr]     <= data;
            wr_seen[addr] <= 1'b1;
        end
    end

    // Reference model: array of slots
    logic   m_valid [N];
    tuple_t m_t     [N];
    int     m_count;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    function automatic tuple_t mk(input logic [31:0] ips, input logic [31:0] ipd,
                                  input logic [15:0] ps, input logic [15:0] pd);
        tuple_t t;
        t.ips = ips; t.ipd = ipd; t.ps = ps; t.pd = pd;
        t.macs = {ps ^ 16'hA5A5, ips};
        t.macd = {pd, ipd ^ 32'h5A5A_0F0F};
        return t;
    endfunction

    function automatic bit same(input tuple_t a, input tuple_t b);
        return a.ips == b.ips && a.ipd == b.ipd && a.ps == b.ps && a.pd == b.pd;
    endfunction

    function automatic int bound_for(input logic [1:0] code);
        return (code == 2'b01) ? 8 * N + 12 : (code == 2'b10) ? 5 : 8 * N + 4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
        m_count = 0;
    endtask

    task automatic model_req(input logic [1:0] code, input logic [7:0] id, input tuple_t t,
                             output logic [7:0] exp, output int exp_wr);
        int hit, fr;
        hit = -1; fr = -1; exp_wr = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (m_valid[i] && same(m_t[i], t)) hit = i;
            if (!m_valid[i]) fr = i;
        end
        case (code)
            2'b01: begin
                if (hit >= 0)     exp = {2'b11, 6'(hit)};
                else if (fr >= 0) begin
                    exp = {2'b01, 6'(fr)}; exp_wr = 8;
                    m_valid[fr] = 1'b1; m_t[fr] = t; m_count++;
                end else          exp = 8'h80;
            end
            2'b11: exp = (hit >= 0) ? {2'b01, 6'(hit)} : 8'h80;
            default: begin
                if (int'(id[5:0]) >= N)      exp = {2'b10, id[5:0]};
                else if (m_valid[id[5:0]]) begin
                    exp = {2'b01, id[5:0]}; exp_wr = 1;
                    m_valid[id[5:0]] = 1'b0; m_count--;
                end else                     exp = {2'b10, id[5:0]};
            end
        endcase
    endtask

    task automatic drive_tuple(input tuple_t t);
        ip_src = t.ips; ip_dst = t.ipd; port_src = t.ps; port_dst = t.pd;
        mac_src = t.macs; mac_dst = t.macd;
    endtask

    task automatic do_req(input logic [1:0] code, input logic [7:0] id, input tuple_t t,
                          input bit scramble, input int bound,
                          output logic [7:0] rep, output int nwr,
                          output logic [7:0] la, output logic [31:0] ld);
        int k;
        bit got;
        @(negedge clk);
        req_code = code; id_in = id; drive_tuple(t);
        nwr = 0; got = 0; rep = 0; la = 0; ld = 0; k = 0;
        while (!got && k < bound + 2) begin
            @(negedge clk);
            k++;
            if (scramble) begin
                id_in = 8'($urandom);
                drive_tuple(mk($urandom, $urandom, 16'($urandom), 16'($urandom)));
            end
            if (wren) begin nwr++; la = addr; ld = data; end
            if (reply != 8'd0) begin got = 1; rep = reply; end
        end
        chk("reply_within_latency", {63'd0, got && (k - 1 <= bound)}, 64'd1);
        @(negedge clk);
        if (wren) begin nwr++; la = addr; ld = data; end
        chk("reply_held", reply, rep);
        req_code = 2'b00;
        @(negedge clk);
        if (wren) begin nwr++; la = addr; ld = data; end
        chk("reply_cleared", reply, 8'd0);
        chk("busy_idle", busy, 1'b0);
    endtask

    task automatic wait_clear_done();
        bit ok;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (!busy && !wren) ok = 1;
        end
        chk("clear_done", ok, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, actual running required done");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [$];
        tuple_t      pool [6];
        tuple_t      tx;
        logic [7:0]  rep, exp, la;
        logic [31:0] ld;
        logic [31:0] ew [8];
        int          nwr, ewr;
        logic [1:0]  code;
        logic [7:0]  id;
        bit          found;
        logic        all_zero;

        rst = 1'b1; req_code = 2'b00; id_in = 8'd0;
        drive_tuple(mk(0, 0, 0, 0));
        model_reset();

        // Reset state
        #1;
        chk("rst_reply", reply, 8'd0);
        chk("rst_wren", wren, 1'b0);
        chk("rst_addr", addr, 8'd0);
        chk("rst_data", data, 32'd0);
        chk("rst_count", count, 5'd0);
        chk("rst_busy", busy, 1'b1);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            chk("clear_wren", wren, 1'b1);
            chk("clear_addr", addr, 8'(8 * i));
            chk("clear_data", data, 32'd0);
        end
        @(negedge clk);
        chk("clear_end_wren", wren, 1'b0);
        chk("clear_end_busy", busy, 1'b0);
        chk("clear_end_count", count, 5'd0);
        all_zero = 1'b1;
        for (int i = 0; i < N; i++) if (ram_rd(8'(8 * i)) != 32'd0) all_zero = 1'b0;
        chk("clear_headers_zero", all_zero, 1'b1);

        // Directed vector table
        vecs.push_back('{2'b01, 8'd0, mk(32'h0A00_0001, 32'h0A00_0002, 16'd80, 16'd5000), 8'h40, 1, 8});
        vecs.push_back('{2'b01, 8'd0, mk(32'h0A00_0001, 32'h0A00_0002, 16'd80, 16'd5000), 8'hC0, 1, 0});
        vecs.push_back('{2'b11, 8'd0, mk(32'h0A00_0001, 32'h0A00_0002, 16'd80, 16'd5000), 8'h40, 1, 0});
        vecs.push_back('{2'b11, 8'd0, mk(32'h0A00_0001, 32'h0A00_0002, 16'd80, 16'd5001), 8'h80, 1, 0});
        for (int i = 1; i < N; i++)
            vecs.push_back('{2'b01, 8'd0, mk(32'h0A00_0001, 32'h0A00_0002, 16'(80 + i), 16'd5000),
                             8'h40 | 8'(i), i + 1, 8});
        vecs.push_back('{2'b01, 8'd0, mk(32'h0A00_0001, 32'h0A00_0002, 16'd96, 16'd5000), 8'h80, 16, 0});
        vecs.push_back('{2'b10, 8'd3, mk(0, 0, 0, 0), 8'h43, 15, 1});
        vecs.push_back('{2'b01, 8'd0, mk(32'h0A00_0001, 32'h0A00_0002, 16'd96, 16'd5000), 8'h43, 16, 8});
        vecs.push_back('{2'b10, 8'd3, mk(0, 0, 0, 0), 8'h43, 15, 1});
        vecs.push_back('{2'b10, 8'd3, mk(0, 0, 0, 0), 8'h83, 15, 0});
        vecs.push_back('{2'b10, 8'd40, mk(0, 0, 0, 0), 8'hA8, 15, 0});
        vecs.push_back('{2'b11, 8'd0, mk(32'h0A00_0001, 32'h0A00_0002, 16'd96, 16'd5000), 8'h80, 15, 0});
        vecs.push_back('{2'b11, 8'd0, mk(32'h0A00_0001, 32'h0A00_0002, 16'd85, 16'd5000), 8'h45, 15, 0});

        foreach (vecs[i]) begin
            model_req(vecs[i].code, vecs[i].id, vecs[i].t, exp, ewr);
            do_req(vecs[i].code, vecs[i].id, vecs[i].t, 1'b1, bound_for(vecs[i].code), rep, nwr, la, ld);
            chk($sformatf("vec%0d_reply", i), rep, vecs[i].exp_reply);
            chk($sformatf("vec%0d_count", i), count, 64'(vecs[i].exp_count));
            chk($sformatf("vec%0d_writes", i), 64'(nwr), 64'(vecs[i].exp_wr));
            if (vecs[i].exp_wr == 8) begin
                chk($sformatf("vec%0d_last_addr", i), la, {vecs[i].exp_reply[4:0], 3'b000});
                chk($sformatf("vec%0d_last_data", i), ld, 32'h8000_0000);
            end
        end

        // Randomized requests against the reference model
        for (int i = 0; i < 6; i++)
            pool[i] = mk(32'hC0A8_0000 + 32'(i), 32'hC0A8_0100 + 32'(i % 3), 16'(1000 + i), 16'(443 + i % 2));
        for (int n = 0; n < 80; n++) begin
            code = 2'($urandom_range(1, 3));
            id   = {2'($urandom), 6'($urandom_range(0, 19))};
            tx   = pool[$urandom_range(0, 5)];
            model_req(code, id, tx, exp, ewr);
            do_req(code, id, tx, 1'b1, bound_for(code), rep, nwr, la, ld);
            chk("rand_reply", rep, exp);
            chk("rand_count", count, 64'(m_count));
            chk("rand_writes", 64'(nwr), 64'(ewr));
            if (code == 2'b01 && exp[7:6] == 2'b01) begin
                ew[0] = 32'h8000_0000; ew[1] = tx.ips; ew[2] = tx.ipd; ew[3] = tx.macs[47:16];
                ew[4] = {tx.macs[15:0], tx.macd[47:32]}; ew[5] = tx.macd[31:0];
                ew[6] = {tx.ps, tx.pd}; ew[7] = 32'd0;
                for (int w = 0; w < 8; w++)
                    chk($sformatf("ram_word%0d", w), ram_rd(8'(8 * int'(exp[5:0]) + w)), ew[w]);
            end
        end

        // Reset in the middle of an entry write
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        model_reset();
        wait_clear_done();
        tx = mk(32'hAC10_0001, 32'hAC10_0002, 16'd1234, 16'd4321);
        @(negedge clk);
        req_code = 2'b01; drive_tuple(tx);
        found = 0;
        for (int i = 0; i < 8 * N + 20 && !found; i++) begin
            @(negedge clk);
            if (wren && addr == 8'd4) found = 1;
        end
        chk("midwrite_reached_word4", found, 1'b1);
        rst = 1'b1;
        #1;
        chk("midwrite_rst_wren", wren, 1'b0);
        chk("midwrite_rst_busy", busy, 1'b1);
        chk("midwrite_rst_count", count, 5'd0);
        @(negedge clk);
        req_code = 2'b00;
        chk("midwrite_hdr_invalid", ram_rd(8'd0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        // Request issued while the table is still clearing must wait, then be served.
        do_req(2'b11, 8'd0, tx, 1'b0, 8 * N + 4 + N + 4, rep, nwr, la, ld);
        chk("midwrite_lookup", rep, 8'h80);
        chk("midwrite_count", count, 5'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
